// File: rtl/arm7tdmi_mem_responder.sv
// Memory-side slave for the cache's single-transfer bus: word RAM with byte-lane
// writes, programmable read/write wait states, range aborts and access counters.
module arm7tdmi_mem_responder #(
    parameter int unsigned            ADDR_WIDTH      = 32,
    parameter int unsigned            MEM_DEPTH_WORDS = 16384,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
    parameter int unsigned            READ_WAIT       = 2,
    parameter int unsigned            WRITE_WAIT      = 1,
    parameter logic [31:0]            INIT_PATTERN    = 32'hCAFE_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_req,
    input  logic                  mem_write,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_byte_en,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_abort,
    output logic                  busy,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic [31:0]           abort_count
);
    localparam int unsigned         IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] LO    = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] HI    = LO + (ADDR_WIDTH+1)'(4 * MEM_DEPTH_WORDS);
    localparam logic [3:0]          RW    = 4'(READ_WAIT);
    localparam logic [3:0]          WW    = 4'(WRITE_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [31:0] ram [MEM_DEPTH_WORDS];

    initial begin
        for (int i = 0; i < int'(MEM_DEPTH_WORDS); i++) ram[i] = INIT_PATTERN + 32'(i);
    end

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  in_range_q, in_range_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic [31:0]           ab_cnt_q, ab_cnt_d;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_write;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_be;
    logic                  cur_in_range;
    logic [IDX_W-1:0]      cur_idx;
    logic                  commit;
    logic                  ram_we;

    // A zero-wait request commits on its sampling edge, so the commit path
    // must see the live bus in IDLE and the latched copy otherwise.
    always_comb begin
        cur_addr     = (state_q == S_IDLE) ? mem_addr    : addr_q;
        cur_write    = (state_q == S_IDLE) ? mem_write   : write_q;
        cur_wdata    = (state_q == S_IDLE) ? mem_wdata   : wdata_q;
        cur_be       = (state_q == S_IDLE) ? mem_byte_en : be_q;
        cur_in_range = ({1'b0, cur_addr} >= LO) && ({1'b0, cur_addr} < HI);
        cur_idx      = cur_addr[IDX_W+1:2];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        in_range_d = in_range_q;
        rdata_d    = rdata_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        ab_cnt_d   = ab_cnt_q;
        commit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    addr_d     = mem_addr;
                    write_d    = mem_write;
                    wdata_d    = mem_wdata;
                    be_d       = mem_byte_en;
                    in_range_d = cur_in_range;
                    cnt_d      = mem_write ? WW : RW;
                    if ((mem_write ? WW : RW) == 4'd0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (!in_range_q)  ab_cnt_d = ab_cnt_q + 32'd1;
                else if (write_q) wr_cnt_d = wr_cnt_q + 32'd1;
                else              rd_cnt_d = rd_cnt_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (commit && !cur_write && cur_in_range) rdata_d = ram[cur_idx];
    end

    // Reset on the committing edge must suppress the RAM write as well.
    assign ram_we = commit && cur_write && cur_in_range && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            in_range_q <= 1'b0;
            rdata_q    <= 32'd0;
            rd_cnt_q   <= 32'd0;
            wr_cnt_q   <= 32'd0;
            ab_cnt_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_range_q <= in_range_d;
            rdata_q    <= rdata_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            ab_cnt_q   <= ab_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        write_q <= write_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) ram[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    assign mem_rdata   = rdata_q;
    assign mem_ready   = (state_q == S_RESP);
    assign mem_abort   = (state_q == S_RESP) && !in_range_q;
    assign busy        = (state_q != S_IDLE);
    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
    assign abort_count = ab_cnt_q;
endmodule
